// File: rtl/prog_loader.sv
// Buffers a valid/ready byte program, pads it to 16 words, bursts it into processor memory, then releases the processor.
// Pad/burst latency: (16-n) PAD + RST1 + 16 BURST + RST2; in_ready is high only while collecting, burst never stalls.
module prog_loader #(
   parameter int          WORDS    = 16,
   parameter logic [7:0]  PAD_WORD = 8'h90
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_load_req,
   input  logic       i_in_valid,
   input  logic [7:0] i_in_data,
   input  logic       i_in_last,
   output logic       o_in_ready,
   output logic       o_mem_write,
   output logic       o_PC_reset,
   output logic [3:0] o_instr,
   output logic [3:0] o_portin,
   output logic       o_busy,
   output logic       o_running,
   output logic [4:0] o_word_count
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_PAD     = 3'd2;
   localparam logic [2:0] S_RST1    = 3'd3;
   localparam logic [2:0] S_BURST   = 3'd4;
   localparam logic [2:0] S_RST2    = 3'd5;
   localparam logic [2:0] S_RUN     = 3'd6;
   localparam logic [4:0] LP_FULL   = 5'(WORDS);

   logic [2:0] r_state, w_nstate;
   logic [4:0] r_wc, w_nwc, w_wc_inc;
   logic [3:0] r_j, w_nj;
   logic [7:0] r_buf [WORDS];
   logic       w_accept, w_wr_en;
   logic [7:0] w_wr_dat, w_burst_dat;

   assign w_accept     = (r_state == S_COLLECT) && i_in_valid && o_in_ready;
   assign w_wc_inc     = r_wc + 5'd1;
   assign o_word_count = r_wc;

   always_comb begin
      w_nstate = r_state;
      w_nwc    = r_wc;
      w_nj     = r_j;
      w_wr_en  = 1'b0;
      w_wr_dat = i_in_data;
      case (r_state)
         S_IDLE, S_RUN: begin
            if (i_load_req) begin
               w_nstate = S_COLLECT;
               w_nwc    = 5'd0;
            end
         end
         S_COLLECT: begin
            if (w_accept) begin
               w_wr_en = 1'b1;
               w_nwc   = w_wc_inc;
               if (i_in_last || (w_wc_inc == LP_FULL))
                  w_nstate = (w_wc_inc < LP_FULL) ? S_PAD : S_RST1;
            end
         end
         S_PAD: begin
            w_wr_en  = 1'b1;
            w_wr_dat = PAD_WORD;
            w_nwc    = w_wc_inc;
            if (w_wc_inc == LP_FULL)
               w_nstate = S_RST1;
         end
         S_RST1: begin
            w_nstate = S_BURST;
            w_nj     = 4'd0;
         end
         S_BURST: begin
            w_nj = r_j + 4'd1;
            if (r_j == 4'd15)
               w_nstate = S_RST2;
         end
         S_RST2:  w_nstate = S_RUN;
         default: w_nstate = S_IDLE;
      endcase
   end

   // PC lands on address 1 first after PC_reset drops, so the burst is rotated by one.
   assign w_burst_dat = r_buf[w_nj + 4'd1];

   always_ff @(posedge i_clk) begin
      if (w_wr_en)
         r_buf[r_wc[3:0]] <= w_wr_dat;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_wc        <= 5'd0;
         r_j         <= 4'd0;
         o_in_ready  <= 1'b0;
         o_mem_write <= 1'b0;
         o_PC_reset  <= 1'b1;
         o_instr     <= 4'd0;
         o_portin    <= 4'd0;
         o_busy      <= 1'b0;
         o_running   <= 1'b0;
      end else begin
         r_state     <= w_nstate;
         r_wc        <= w_nwc;
         r_j         <= w_nj;
         o_in_ready  <= (w_nstate == S_COLLECT) && (w_nwc < LP_FULL);
         o_mem_write <= (w_nstate == S_BURST);
         o_PC_reset  <= !((w_nstate == S_BURST) || (w_nstate == S_RUN));
         {o_instr, o_portin} <= (w_nstate == S_BURST) ? w_burst_dat : 8'h00;
         o_busy      <= (w_nstate == S_COLLECT) || (w_nstate == S_PAD) ||
                        (w_nstate == S_RST1) || (w_nstate == S_BURST) ||
                        (w_nstate == S_RST2);
         o_running   <= (w_nstate == S_RUN);
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: full, short, gapped, restart, ignored request and async reset cases.
module tb_prog_loader;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_load_req = 1'b0;
   logic       i_in_valid = 1'b0;
   logic [7:0] i_in_data = 8'h00;
   logic       i_in_last = 1'b0;
   logic       o_in_ready, o_mem_write, o_PC_reset, o_busy, o_running;
   logic [3:0] o_instr, o_portin;
   logic [4:0] o_word_count;

   int n_assert = 0;
   int n_fail   = 0;
   logic [7:0] mdl [16];

   prog_loader dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load_req(i_load_req),
      .i_in_valid(i_in_valid), .i_in_data(i_in_data), .i_in_last(i_in_last),
      .o_in_ready(o_in_ready), .o_mem_write(o_mem_write), .o_PC_reset(o_PC_reset),
      .o_instr(o_instr), .o_portin(o_portin), .o_busy(o_busy),
      .o_running(o_running), .o_word_count(o_word_count)
   );

   initial forever #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sends n bytes base+i, last flag on the final one, with up to max_gap idle cycles before each.
   task automatic load_seq(input logic [7:0] base, input int n, input int max_gap);
      for (int i = 0; i < n; i++) begin
         int g;
         g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         i_in_valid = 1'b0;
         repeat (g) step();
         i_in_valid = 1'b1;
         i_in_data  = base + 8'(i);
         i_in_last  = (i == n - 1);
         mdl[i]     = base + 8'(i);
         step();
         check($sformatf("wc_after_byte%0d", i), o_word_count, i + 1);
      end
   endtask

   task automatic burst(input int ncyc, input int pulse_at);
      for (int j = 0; j < ncyc; j++) begin
         step();
         i_load_req = (j == pulse_at);
         check($sformatf("burst%0d_we", j), o_mem_write, 1);
         check($sformatf("burst%0d_pcr", j), o_PC_reset, 0);
         check($sformatf("burst%0d_dat", j), {o_instr, o_portin}, mdl[(j + 1) % 16]);
      end
   endtask

   task automatic finish_burst();
      step();
      i_load_req = 1'b0;
      check("rst2_pcr", o_PC_reset, 1);
      check("rst2_we", o_mem_write, 0);
      check("rst2_dat", {o_instr, o_portin}, 8'h00);
      check("rst2_busy", o_busy, 1);
      step();
      check("run_running", o_running, 1);
      check("run_pcr", o_PC_reset, 0);
      check("run_busy", o_busy, 0);
   endtask

   task automatic request_load(input string tag);
      i_load_req = 1'b1;
      step();
      i_load_req = 1'b0;
      check({tag, "_rdy"}, o_in_ready, 1);
      check({tag, "_wc"}, o_word_count, 0);
      check({tag, "_pcr"}, o_PC_reset, 1);
      check({tag, "_running"}, o_running, 0);
      check({tag, "_busy"}, o_busy, 1);
   endtask

   initial begin
      int n_pad;
      repeat (3) step();
      check("rst_rdy", o_in_ready, 0);
      check("rst_we", o_mem_write, 0);
      check("rst_pcr", o_PC_reset, 1);
      check("rst_instr", o_instr, 0);
      check("rst_portin", o_portin, 0);
      check("rst_busy", o_busy, 0);
      check("rst_running", o_running, 0);
      check("rst_wc", o_word_count, 0);
      #3 i_rst_n = 1'b1;
      step();
      check("idle_rdy", o_in_ready, 0);
      check("idle_pcr", o_PC_reset, 1);

      // Full gapless load: no PAD, RST1 right after the 16th accept.
      request_load("full_req");
      load_seq(8'h60, 16, 0);
      i_in_valid = 1'b0;
      i_in_last  = 1'b0;
      check("full_rst1_rdy", o_in_ready, 0);
      check("full_rst1_we", o_mem_write, 0);
      check("full_rst1_pcr", o_PC_reset, 1);
      burst(16, -1);
      finish_burst();

      // Restart from RUN, then a 3-byte program padded with jumps.
      request_load("restart");
      i_in_valid = 1'b1;
      i_in_last = 1'b0; i_in_data = 8'h65; step();
      i_in_data = 8'h70; step();
      i_in_last = 1'b1; i_in_data = 8'h90; step();
      i_in_valid = 1'b0;
      i_in_last  = 1'b0;
      check("short_wc", o_word_count, 3);
      check("short_rdy", o_in_ready, 0);
      mdl[0] = 8'h65;
      mdl[1] = 8'h70;
      for (int i = 2; i < 16; i++) mdl[i] = 8'h90;
      n_pad = 0;
      while (o_word_count < 5'd16 && n_pad < 40) begin
         n_pad++;
         step();
      end
      check("short_pad_cycles", n_pad, 13);
      check("short_wc_full", o_word_count, 16);
      check("short_rst1_we", o_mem_write, 0);
      burst(16, -1);
      finish_burst();

      // Gapped load with in_valid held high after the last byte; load_req pulsed mid-burst.
      request_load("bp_req");
      load_seq(8'h60, 16, 3);
      i_in_data = 8'hEE;
      i_in_last = 1'b0;
      check("bp_rdy_after16", o_in_ready, 0);
      check("bp_wc16", o_word_count, 16);
      burst(16, 5);
      i_in_valid = 1'b0;
      check("bp_wc_hold", o_word_count, 16);
      finish_burst();

      // Async reset in burst cycle 8.
      request_load("ar_req");
      load_seq(8'hC0, 16, 0);
      i_in_valid = 1'b0;
      i_in_last  = 1'b0;
      burst(9, -1);
      #3 i_rst_n = 1'b0;
      #1;
      check("ar_we", o_mem_write, 0);
      check("ar_pcr", o_PC_reset, 1);
      check("ar_busy", o_busy, 0);
      step();
      #2 i_rst_n = 1'b1;
      repeat (3) step();
      check("ar_idle_rdy", o_in_ready, 0);
      check("ar_idle_wc", o_word_count, 0);
      check("ar_idle_running", o_running, 0);
      check("ar_idle_pcr", o_PC_reset, 1);
      request_load("ar_reload");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream feeder for the 4-bit processor control block. It drives that block's program-load inputs: mem_write, PC_reset, instr and portin.
- Accepts a program as a valid/ready byte stream: opcode in bits [7:4], operand in bits [3:0]. Buffers the whole program internally, then bursts it into processor program memory in back-to-back cycles.
- A full buffer is required because the processor PC advances on every falling clock edge while PC_reset is low. Writes therefore cannot stall.
- After the burst it resets the processor PC and releases the processor to run.

Parameters:
- WORDS, 16, program memory depth. Must equal 2^4 to match the 4-bit PC.
- PAD_WORD, 8'h90, fill word for short programs. 8'h90 is an unconditional jump to address 0.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_req  in  1  single-cycle pulse; starts a new program load.
- in_valid  in  1  byte stream valid.
- in_data  in  8  program byte: [7:4] opcode, [3:0] operand.
- in_last  in  1  marks final byte of program; qualified by in_valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_write  out  1  to processor: program-memory write enable.
- PC_reset  out  1  to processor: PC reset and execution hold.
- instr  out  4  to processor: opcode nibble of the word being written.
- portin  out  4  to processor: operand nibble of the word being written.
- busy  out  1  high in COLLECT, PAD, RST1, BURST, RST2.
- running  out  1  high in RUN.
- word_count  out  5  number of words held in the buffer (0..16).

Behaviour:
- Output timing: all outputs are registered and reflect the current state during that cycle. The buffer is 16 x 8 registers; buf[i] holds the program word for address i.
- Reset (async, rst_n=0): state IDLE, in_ready=0, mem_write=0, PC_reset=1, instr=0, portin=0, busy=0, running=0, word_count=0. Buffer contents are not reset.
- IDLE:
  - PC_reset=1, so the processor is held.
  - load_req -> COLLECT with word_count cleared.
- COLLECT:
  - in_ready = (word_count<16).
  - On in_valid&in_ready: buf[word_count]<=in_data and word_count increments.
  - If the accepted byte has in_last=1, or is the 16th byte: go to PAD when word_count after increment <16, otherwise go to RST1.
  - in_ready drops in the cycle after the terminating accept. Bytes are never accepted outside COLLECT.
  - in_valid gaps are allowed; the loader waits indefinitely.
- PAD: writes PAD_WORD to buf[word_count], one per cycle, until word_count=16, then goes to RST1.
- RST1: one cycle. PC_reset=1, mem_write=0.
- BURST: 16 consecutive cycles, j=0..15.
  - mem_write=1, PC_reset=0.
  - {instr,portin}=buf[(j+1) mod 16].
  - The rotated order is required because the processor PC steps to 1 on the falling edge right after PC_reset deasserts. Write j therefore lands at address (j+1) mod 16.
  - Emit order is buf[1]..buf[15], buf[0].
- RST2: one cycle. PC_reset=1, mem_write=0, instr/portin=0. Then go to RUN.
- RUN: PC_reset=0, mem_write=0, running=1. load_req -> COLLECT, with PC_reset=1 from the next cycle, halting the processor.
- PC_reset: 1 in IDLE, COLLECT, PAD, RST1, RST2. 0 in BURST and RUN.
- mem_write: 1 only in BURST.
- load_req is ignored in COLLECT, PAD, RST1, BURST and RST2.
- Latency: from the terminating accept, (16 - words received) PAD cycles, then 1 RST1 + 16 BURST + 1 RST2, then RUN.
- Reset mid-burst returns to IDLE immediately and drops mem_write asynchronously. The partially written program is not recovered; a new load is required.

Test Plan:
- Full load: load_req, then 16 bytes 8'h60..8'h6F with no gaps and in_last on byte 16. Required: no PAD cycles, 1 RST1 cycle, then 16 BURST cycles emitting 8'h61..8'h6F then 8'h60, then 1 RST2 cycle, then RUN with running=1.
- Short load: 3 bytes 8'h65, 8'h70, 8'h90 with in_last on byte 3. Required: 13 PAD cycles, word_count=16; BURST emits 8'h70, 8'h90, thirteen 8'h90 fill words, then 8'h65.
- Backpressure: random 0-3 cycle in_valid gaps across 16 bytes. Required: buffer contents identical to the gapless case; in_ready=0 after the 16th accept even if in_valid stays high.
- Restart: load_req in RUN. Required: next cycle PC_reset=1, running=0, in_ready=1, word_count=0.
- Ignored request: load_req pulsed during BURST cycle 5. Required: burst completes unchanged and reaches RUN.
- Async reset: rst_n low at BURST cycle 8, mid-cycle. Required: mem_write=0 and PC_reset=1 immediately; state IDLE after release; in_ready=0 until the next load_req.
